// File: rtl/bit_comp4d.sv
// Registered magnitude comparator built from a cascade of 1-bit compare slices.
// Produces a one-hot {gt, eq, lt} code one cycle after each captured operand pair.
module bit_comp4d #(
  parameter int WIDTH      = 4,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [2:0]       out,
  output logic             out_valid
);

  logic [2:0] out_d, out_q;
  logic       valid_d, valid_q;

  // Walk the slices from the MSB; a lower slice only decides while every slice above it is equal.
  always_comb begin
    logic gtAcc, ltAcc, eqAcc, gBit, lBit, tmpBit;
    gtAcc = 1'b0;
    ltAcc = 1'b0;
    eqAcc = 1'b1;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      gBit = a[i] & ~b[i];
      lBit = ~a[i] & b[i];
      if (SIGNED_CMP && (i == WIDTH - 1)) begin
        tmpBit = gBit;
        gBit   = lBit;
        lBit   = tmpBit;
      end
      gtAcc = gtAcc | (eqAcc & gBit);
      ltAcc = ltAcc | (eqAcc & lBit);
      eqAcc = eqAcc & ~(a[i] ^ b[i]);
    end
    out_d   = {gtAcc, eqAcc, ltAcc};
    valid_d = in_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= 3'b000;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (in_valid) begin
        out_q <= out_d;
      end
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_bit_comp4d.sv
// Self-checking bench for bit_comp4d: unsigned, signed and 1-bit instances
// checked every cycle against an arithmetic reference model, plus directed vectors.
module tb_bit_comp4d;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tbValid;
  logic [3:0] tbA, tbB;
  logic [2:0] outU, outS, out1;
  logic       validU, validS, valid1;

  int total = 0;
  int bad   = 0;

  logic [2:0] expOut [3];
  logic       expValid;

  always #5 clk = ~clk;

  bit_comp4d #(.WIDTH(4), .SIGNED_CMP(1'b0)) dutU (
    .clk(clk), .rst_n(rst_n), .in_valid(tbValid), .a(tbA), .b(tbB),
    .out(outU), .out_valid(validU)
  );

  bit_comp4d #(.WIDTH(4), .SIGNED_CMP(1'b1)) dutS (
    .clk(clk), .rst_n(rst_n), .in_valid(tbValid), .a(tbA), .b(tbB),
    .out(outS), .out_valid(validS)
  );

  bit_comp4d #(.WIDTH(1), .SIGNED_CMP(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(tbValid), .a(tbA[0]), .b(tbB[0]),
    .out(out1), .out_valid(valid1)
  );

  // Reference compare on plain integers, sign-extending when asked.
  function automatic logic [2:0] refCmp(input int av, input int bv, input int w, input bit sgn);
    int x, y;
    x = av;
    y = bv;
    if (sgn && x >= (1 << (w - 1))) x = x - (1 << w);
    if (sgn && y >= (1 << (w - 1))) y = y - (1 << w);
    return {x > y, x == y, x < y};
  endfunction

  // Model state mirrors what each instance should present after the latest edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expValid  = 1'b0;
      expOut[0] = 3'b000;
      expOut[1] = 3'b000;
      expOut[2] = 3'b000;
    end else begin
      expValid = tbValid;
      if (tbValid) begin
        expOut[0] = refCmp(int'(tbA), int'(tbB), 4, 1'b0);
        expOut[1] = refCmp(int'(tbA), int'(tbB), 4, 1'b1);
        expOut[2] = refCmp(int'(tbA[0]), int'(tbB[0]), 1, 1'b0);
      end
    end
  end

  task automatic cmpOne(input string name, input logic [2:0] o, input logic v,
                        input logic [2:0] eo, input logic ev);
    total++;
    if ({v, o} !== {ev, eo}) begin
      bad++;
      $display("[TB] FAIL %s: got valid=%b out=%b, want valid=%b out=%b", name, v, o, ev, eo);
    end
    if (v === 1'b1) begin
      total++;
      if (!$onehot(o)) begin
        bad++;
        $display("[TB] FAIL %s_onehot: got out=%b, want exactly one bit set", name, o);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      cmpOne("model_u4", outU, validU, expOut[0], expValid);
      cmpOne("model_s4", outS, validS, expOut[1], expValid);
      cmpOne("model_w1", out1, valid1, expOut[2], expValid);
    end
  end

  task automatic applyStimulus(input logic v, input logic [3:0] av, input logic [3:0] bv);
    @(negedge clk);
    tbValid = v;
    tbA     = av;
    tbB     = bv;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got {valid,out}=%b, want %b", name, act, exp);
    end
  endtask

  // Drive one pair, then inspect just after the capture edge.
  task automatic runVec(input string name, input logic [3:0] av, input logic [3:0] bv,
                        input logic sgn, input logic [2:0] exp);
    applyStimulus(1'b1, av, bv);
    @(posedge clk);
    #1;
    if (sgn) checkOutput(name, {validS, outS}, {1'b1, exp});
    else     checkOutput(name, {validU, outU}, {1'b1, exp});
  endtask

  initial begin
    rst_n   = 1'b0;
    tbValid = 1'b0;
    tbA     = 4'h0;
    tbB     = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_u4", {validU, outU}, 4'b0000);
    checkOutput("reset_s4", {validS, outS}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back directed vectors.
    runVec("t2_0_0", 4'h0, 4'h0, 1'b0, 3'b010);
    runVec("t2_1_0", 4'h1, 4'h0, 1'b0, 3'b100);
    checkOutput("w1_1_0", {valid1, out1}, 4'b1100);
    runVec("t2_0_1", 4'h0, 4'h1, 1'b0, 3'b001);
    runVec("t3_8_7", 4'h8, 4'h7, 1'b0, 3'b100);
    runVec("t3_F_E", 4'hF, 4'hE, 1'b0, 3'b100);
    runVec("t3_F_F", 4'hF, 4'hF, 1'b0, 3'b010);
    checkOutput("t3_F_F_signed", {validS, outS}, 4'b1010);
    runVec("t4_8_7", 4'h8, 4'h7, 1'b1, 3'b001);
    runVec("t4_F_0", 4'hF, 4'h0, 1'b1, 3'b001);
    runVec("t4_7_8", 4'h7, 4'h8, 1'b1, 3'b100);

    // Hold: result stays, valid drops, random operands ignored.
    runVec("t5_3_5", 4'h3, 4'h5, 1'b0, 3'b001);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      @(posedge clk);
      #1;
      checkOutput("t5_hold", {validU, outU}, 4'b0001);
    end

    // Asynchronous reset between edges must clear immediately.
    runVec("t1_pre", 4'h9, 4'h2, 1'b0, 3'b100);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t1_async_u4", {validU, outU}, 4'b0000);
    checkOutput("t1_async_s4", {validS, outS}, 4'b0000);
    @(negedge clk);
    tbValid = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t1_no_stale", {validU, outU}, 4'b0000);

    // Exhaustive sweep, checked by the per-cycle model compare.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        applyStimulus(1'b1, 4'(i), 4'(j));
      end
    end
    applyStimulus(1'b0, 4'h0, 4'h0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
